// File: rtl/sistema_sweep_ctrl.sv
// sistema_sweep_ctrl: drives {A,B,C,D} of one sistema instance through all
// 16 input combinations and records H into a truth table with a ones count.
// Optional build macro SWEEP_CMP_EN: compares each captured H against
// `expected` and records the first failing vector. When it is undefined,
// mismatch and mismatch_idx are tied to 0 and no compare logic exists.
module sistema_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  abcd,
    input  logic        h,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [4:0]  ones_count,
    input  logic [15:0] expected,
    output logic        mismatch,
    output logic [3:0]  mismatch_idx
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    // Loaded on acceptance: the acceptance cycle itself is an arming cycle,
    // so vector 0 settles from E0+1 like every later vector.
    localparam logic [CNT_W-1:0] CNT_ARM  = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;

    // Sweep sequencer: vector stepping, settle timing, capture and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            settle_cnt  <= '0;
            abcd        <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= 16'd0;
            ones_count  <= 5'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_SETTLE;
                        settle_cnt  <= CNT_ARM;
                        abcd        <= 4'd0;
                        truth_table <= 16'd0;
                        ones_count  <= 5'd0;
                    end
                end
                ST_SETTLE: begin
                    busy       <= 1'b1;
                    settle_cnt <= settle_cnt + CNT_W'(1);
                    if (settle_cnt == CNT_LAST) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    truth_table[abcd] <= h;
                    ones_count        <= ones_count + 5'(h);
                    if (abcd == 4'hF) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        abcd       <= abcd + 4'd1;
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SWEEP_CMP_EN
    // Sticky first-failure capture against the reference truth table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch     <= 1'b0;
            mismatch_idx <= 4'd0;
        end else if ((state == ST_IDLE) && start) begin
            mismatch     <= 1'b0;
            mismatch_idx <= 4'd0;
        end else if ((state == ST_SAMPLE) && !mismatch && (h != expected[abcd])) begin
            mismatch     <= 1'b1;
            mismatch_idx <= abcd;
        end
    end
`else
    // Compare disabled: flags are constant and the reference input is sunk
    logic unused_expected;
    assign unused_expected = ^expected;
    assign mismatch        = 1'b0;
    assign mismatch_idx    = 4'd0;
`endif

endmodule

// File: tb/tb_sistema_sweep_ctrl.sv
// Scoreboard bench for sistema_sweep_ctrl: drivers queue one expected-sweep
// record per accepted start; a monitor checks every cycle against a model
// derived from the sweep timing rules and pops the record on done.
module tb_sistema_sweep_ctrl;

    localparam int S      = 2;
    localparam int P      = S + 1;
    localparam int T_DONE = 16 * P + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  abcd;
    logic        h = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] truth_table;
    logic [4:0]  ones_count;
    logic [15:0] expected = 16'd0;
    logic        mismatch;
    logic [3:0]  mismatch_idx;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          e0;
        logic [15:0] tbl;
        logic [15:0] exp;
    } rec_t;

    rec_t q[$];

    logic [15:0] hold_tt   = 16'd0;
    logic [4:0]  hold_ones = 5'd0;
    logic [3:0]  hold_abcd = 4'd0;
    logic        hold_mm   = 1'b0;
    logic [3:0]  hold_idx  = 4'd0;

    sistema_sweep_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abcd         (abcd),
        .h            (h),
        .busy         (busy),
        .done         (done),
        .truth_table  (truth_table),
        .ones_count   (ones_count),
        .expected     (expected),
        .mismatch     (mismatch),
        .mismatch_idx (mismatch_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Results after the first n vectors of a sweep have been captured
    function automatic void model(input rec_t r, input int n, output logic [15:0] tt,
                                  output logic [4:0] ones, output logic mm, output logic [3:0] idx);
        tt = 16'd0; ones = 5'd0; mm = 1'b0; idx = 4'd0;
        for (int k = 0; k < n; k++) begin
            tt[k] = r.tbl[k];
            ones  = ones + 5'(r.tbl[k]);
`ifdef SWEEP_CMP_EN
            if (!mm && (r.tbl[k] != r.exp[k])) begin
                mm  = 1'b1;
                idx = 4'(k);
            end
`endif
        end
    endfunction

    task automatic idle_check();
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_done", 32'(done), 32'(0));
        chk("idle_abcd", 32'(abcd), 32'(hold_abcd));
        chk("idle_tt", 32'(truth_table), 32'(hold_tt));
        chk("idle_ones", 32'(ones_count), 32'(hold_ones));
        chk("idle_mismatch", 32'(mismatch), 32'(hold_mm));
        chk("idle_mm_idx", 32'(mismatch_idx), 32'(hold_idx));
    endtask

    // Monitor: per-cycle checks; h is the recorded table only on capture cycles, noise otherwise
    initial begin
        rec_t        r;
        int          t;
        int          n;
        logic [15:0] tt;
        logic [4:0]  ones;
        logic        mm;
        logic [3:0]  idx;
        forever begin
            @(negedge clk);
            #1;
            h = 1'($urandom);
            if (q.size() == 0) begin
                idle_check();
            end else begin
                r = q[0];
                t = cyc - r.e0;
                if (t < 0) begin
                    idle_check();
                end else if (t == T_DONE) begin
                    model(r, 16, tt, ones, mm, idx);
                    chk("done_pulse", 32'(done), 32'(1));
                    chk("done_busy", 32'(busy), 32'(0));
                    chk("done_abcd", 32'(abcd), 32'(15));
                    chk("final_tt", 32'(truth_table), 32'(tt));
                    chk("final_ones", 32'(ones_count), 32'(ones));
                    chk("final_mismatch", 32'(mismatch), 32'(mm));
                    chk("final_mm_idx", 32'(mismatch_idx), 32'(idx));
                    hold_tt = tt; hold_ones = ones; hold_abcd = 4'hF;
                    hold_mm = mm; hold_idx = idx;
                    void'(q.pop_front());
                end else begin
                    n = (t == 0) ? 0 : (t - 1) / P;
                    model(r, n, tt, ones, mm, idx);
                    chk("sweep_busy", 32'(busy), 32'(t >= 1));
                    chk("sweep_done", 32'(done), 32'(0));
                    chk("sweep_abcd", 32'(abcd), 32'(n));
                    chk("sweep_tt", 32'(truth_table), 32'(tt));
                    chk("sweep_ones", 32'(ones_count), 32'(ones));
                    chk("sweep_mismatch", 32'(mismatch), 32'(mm));
                    chk("sweep_mm_idx", 32'(mismatch_idx), 32'(idx));
                    if ((t >= P) && (t % P == 0)) h = r.tbl[t / P - 1];
                end
            end
        end
    end

    task automatic wait_until(input int target);
        for (int i = 0; i < 5000 && cyc < target; i++) @(negedge clk);
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while (q.size() != 0 && i < 3000) begin
            @(negedge clk);
            i++;
        end
        chk("drain_timeout", 32'(q.size()), 32'(0));
        q.delete();
    endtask

    task automatic issue(input logic [15:0] tbl, input logic [15:0] ex, output int e0);
        rec_t r;
        @(negedge clk);
        expected = ex;
        start    = 1'b1;
        e0       = cyc + 1;
        r.e0 = e0; r.tbl = tbl; r.exp = ex;
        q.push_back(r);
    endtask

    task automatic run_sweep(input logic [15:0] tbl, input logic [15:0] ex, input bit pulses);
        int e0;
        issue(tbl, ex, e0);
        @(negedge clk);
        start = 1'b0;
        if (pulses) begin
            wait_until(e0 + 9);  start = 1'b1; @(negedge clk); start = 1'b0;
            wait_until(e0 + 29); start = 1'b1; @(negedge clk); start = 1'b0;
        end
        wait_drain();
    endtask

    task automatic run_b2b(input int nsw, input logic [15:0] ex);
        rec_t r;
        int   e0;
        int   d;
        issue(16'($urandom), ex, e0);
        for (int i = 0; i < nsw; i++) begin
            d = e0 + T_DONE;
            wait_until(d + 1);
            if (i < nsw - 1) begin
                e0 = d + 2;
                r.e0 = e0; r.tbl = 16'($urandom); r.exp = ex;
                q.push_back(r);
            end else begin
                start = 1'b0;
            end
        end
        wait_drain();
    endtask

    task automatic run_reset_mid();
        int e0;
        issue(16'($urandom), 16'($urandom), e0);
        @(negedge clk);
        start = 1'b0;
        wait_until(e0 + 1 + 7 * P + 1);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_abcd", 32'(abcd), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_tt", 32'(truth_table), 32'(0));
        chk("rst_ones", 32'(ones_count), 32'(0));
        chk("rst_mismatch", 32'(mismatch), 32'(0));
        chk("rst_mm_idx", 32'(mismatch_idx), 32'(0));
        q.delete();
        hold_tt = 16'd0; hold_ones = 5'd0; hold_abcd = 4'd0;
        hold_mm = 1'b0; hold_idx = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Stimulus sequence
    initial begin
        logic [15:0] fn;
        logic [15:0] tbl;
        logic [15:0] ex;
        for (int k = 0; k < 16; k++) begin
            logic a, b, c, d;
            a = k[3]; b = k[2]; c = k[1]; d = k[0];
            fn[k] = (a & b) | (c & ~d);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        run_sweep(fn, fn, 1'b0);
        run_sweep(16'hFFFF, 16'hFFFF, 1'b1);
        run_sweep(fn ^ 16'h0220, fn, 1'b0);
        run_reset_mid();
        run_sweep(fn, 16'($urandom), 1'b0);
        run_b2b(3, 16'($urandom));
        for (int i = 0; i < 6; i++) begin
            tbl = 16'($urandom);
            ex  = (i % 2 == 0) ? tbl : (tbl ^ (16'($urandom) & 16'($urandom) & 16'($urandom)));
            repeat ($urandom_range(0, 4)) @(negedge clk);
            run_sweep(tbl, ex, 1'($urandom));
        end
        run_sweep(16'h0000, 16'hFFFF, 1'b0);
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time bound on the whole run
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
